// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter:
// ALU opcodes, arbiter states and opcode legality check.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD,
            ALU_SLT, ALU_XOR, ALU_SUB,
            ALU_SRL, ALU_SLL, ALU_SRA: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle RV32-style ALU.
// Undefined opcodes produce a zero result.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [3:0]       alu_op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt  = op2_i[SHW-1:0];
    assign zero_o = (result_o == '0);

    // Combinational operation select
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_AND: result_o = op1_i & op2_i;
            ALU_OR:  result_o = op1_i | op2_i;
            ALU_ADD: result_o = op1_i + op2_i;
            ALU_SLT: result_o[0] = $signed(op1_i) < $signed(op2_i);
            ALU_XOR: result_o = op1_i ^ op2_i;
            ALU_SUB: result_o = op1_i - op2_i;
            ALU_SRL: result_o = op1_i >> shamt;
            ALU_SLL: result_o = op1_i << shamt;
            ALU_SRA: result_o = $unsigned($signed(op1_i) >>> shamt);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Rotating-priority one-hot picker: the first set
// request at or above ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   ptr_i,
    output logic [N-1:0] gnt_o
);

    logic found;
    int   idx;

    // Scan upward from the pointer, keep only the first hit
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with
// round-robin arbitration, optional lock and a 1-cycle response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [NUM_REQ*WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*WIDTH-1:0] req_op2,
    input  logic [NUM_REQ*4-1:0]     req_alu_op,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_illegal,
    output logic                     state_locked,
    output logic [31:0]              op_count
);

    arb_state_e state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] owner_q, owner_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] ready;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   mux_op1;
    logic [WIDTH-1:0]   mux_op2;
    logic [3:0]         mux_op;
    logic               xfer;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_zero;

    logic               rsp_valid_q;
    logic [1:0]         rsp_id_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic               rsp_zero_q;
    logic               rsp_illegal_q;
    logic [31:0]        op_count_q;

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        logic [1:0] nxt;
        if (int'(idx) >= NUM_REQ - 1) nxt = 2'd0;
        else                          nxt = idx + 2'd1;
        return nxt;
    endfunction

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req_i(req_valid),
        .ptr_i(rr_ptr_q),
        .gnt_o(arb_gnt)
    );

    // Grant: rotating pick in ARB, owner only in LOCK, nothing in reset
    always_comb begin
        ready = '0;
        if (!rst) begin
            if (state_q == ST_ARB) begin
                ready = arb_gnt;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (owner_q == 2'(k)) ready[k] = req_valid[k];
                end
            end
        end
    end

    assign req_ready = ready;
    assign xfer      = |(req_valid & ready);

    // Steer the granted requester's fields onto the ALU
    always_comb begin
        sel     = 2'd0;
        mux_op1 = '0;
        mux_op2 = '0;
        mux_op  = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ready[k]) begin
                sel     = 2'(k);
                mux_op1 = req_op1[k*WIDTH +: WIDTH];
                mux_op2 = req_op2[k*WIDTH +: WIDTH];
                mux_op  = req_alu_op[k*4 +: 4];
            end
        end
    end

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op1_i   (mux_op1),
        .op2_i   (mux_op2),
        .alu_op_i(mux_op),
        .result_o(alu_res),
        .zero_o  (alu_zero)
    );

    // Next state: enter LOCK on a locked transfer, leave when lock drops
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            ST_ARB: begin
                if (xfer) begin
                    rr_ptr_d = ptr_after(sel);
                    if (req_lock[sel]) begin
                        state_d = ST_LOCK;
                        owner_d = sel;
                    end
                end
            end
            ST_LOCK: begin
                if (!req_lock[owner_q]) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = ptr_after(owner_q);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Arbiter state, pointer and lock owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= 2'd0;
            owner_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Response register: valid pulses per transfer, payload holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 2'd0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            rsp_valid_q <= xfer;
            if (xfer) begin
                rsp_id_q      <= sel;
                rsp_result_q  <= alu_res;
                rsp_zero_q    <= alu_zero;
                rsp_illegal_q <= ~op_is_legal(mux_op);
            end
        end
    end

    // Transfer counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       op_count_q <= 32'd0;
        else if (xfer) op_count_q <= op_count_q + 32'd1;
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign state_locked = (state_q == ST_LOCK);
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter
// with two requesters and hand-computed expectations.
module tb_alu_share_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_lock;
    logic [N*W-1:0] req_op1;
    logic [N*W-1:0] req_op2;
    logic [N*4-1:0] req_alu_op;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic           rsp_illegal;
    logic           state_locked;
    logic [31:0]    op_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_alu_op  (req_alu_op),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .state_locked(state_locked),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid[i]         = v;
        req_lock[i]          = l;
        req_alu_op[i*4 +: 4] = op;
        req_op1[i*W +: W]    = a;
        req_op2[i*W +: W]    = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid  = '0;
        req_lock   = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_alu_op = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        check("rst_illegal", 32'(rsp_illegal), 32'd0);
        check("rst_locked", 32'(state_locked), 32'd0);
        check("rst_count", op_count, 32'd0);
        rst = 1'b0;

        // Single ADD from requester 0
        set_req(0, 1'b1, 1'b0, 4'b0010, 32'd20, 32'd22);
        #1 check("add_ready", 32'(req_ready), 32'h1);
        step();
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_id", 32'(rsp_id), 32'd0);
        check("add_result", rsp_result, 32'h2A);
        check("add_zero", 32'(rsp_zero), 32'd0);
        check("add_count", op_count, 32'd1);
        clear_reqs();
        step();
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_hold", rsp_result, 32'h2A);

        // Contention: grants alternate 0,1,0,1
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'b0110, 32'd50, 32'd30);
        set_req(1, 1'b1, 1'b0, 4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A);
        for (int k = 0; k < 4; k++) begin
            #1 check("rr_ready", 32'(req_ready),
                     (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check("rr_valid", 32'(rsp_valid), 32'd1);
            check("rr_id", 32'(rsp_id), 32'(k % 2));
            check("rr_result", rsp_result,
                  (k % 2 == 0) ? 32'h14 : 32'h0);
            check("rr_zero", 32'(rsp_zero), 32'(k % 2));
        end
        clear_reqs();
        check("rr_count", op_count, 32'd4);

        // Lock: requester 1 keeps the ALU for three shifts
        do_reset();
        set_req(1, 1'b1, 1'b1, 4'b1000, 32'hFFFFFFFF, 32'd4);
        #1 check("lk_ready0", 32'(req_ready), 32'h2);
        check("lk_unlocked", 32'(state_locked), 32'd0);
        step();
        check("lk_srl", rsp_result, 32'h0FFFFFFF);
        check("lk_id", 32'(rsp_id), 32'd1);
        check("lk_locked", 32'(state_locked), 32'd1);
        set_req(0, 1'b1, 1'b0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 1'b1, 1'b1, 4'b1001, 32'hFFFFFFFF, 32'd4);
        #1 check("lk_ready1", 32'(req_ready), 32'h2);
        step();
        check("lk_sll", rsp_result, 32'hFFFFFFF0);
        set_req(1, 1'b1, 1'b0, 4'b1010, 32'hFFFFFFFF, 32'd4);
        #1 check("lk_ready2", 32'(req_ready), 32'h2);
        step();
        check("lk_sra", rsp_result, 32'hFFFFFFFF);
        check("lk_sra_id", 32'(rsp_id), 32'd1);
        check("lk_released", 32'(state_locked), 32'd0);
        set_req(1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        #1 check("lk_ready3", 32'(req_ready), 32'h1);
        step();
        check("lk_r0_id", 32'(rsp_id), 32'd0);
        check("lk_r0_result", rsp_result, 32'd2);
        clear_reqs();

        // Illegal opcode then XOR
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'b1111, 32'd5, 32'd3);
        step();
        check("ill_valid", 32'(rsp_valid), 32'd1);
        check("ill_flag", 32'(rsp_illegal), 32'd1);
        set_req(0, 1'b1, 1'b0, 4'b0101, 32'h12345678, 32'h87654321);
        step();
        check("xor_valid", 32'(rsp_valid), 32'd1);
        check("xor_result", rsp_result, 32'h95511559);
        check("xor_flag", 32'(rsp_illegal), 32'd0);
        clear_reqs();

        // Asynchronous reset while locked with a response pending
        do_reset();
        set_req(1, 1'b1, 1'b1, 4'b0010, 32'd1, 32'd2);
        step();
        check("mr_pending", 32'(rsp_valid), 32'd1);
        check("mr_locked", 32'(state_locked), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_valid", 32'(rsp_valid), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        check("mr_unlocked", 32'(state_locked), 32'd0);
        check("mr_count", op_count, 32'd0);
        set_req(0, 1'b1, 1'b0, 4'b0010, 32'd3, 32'd4);
        set_req(1, 1'b1, 1'b0, 4'b0010, 32'd1, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mr_first", 32'(req_ready), 32'h1);
        step();
        check("mr_id", 32'(rsp_id), 32'd0);
        check("mr_result", rsp_result, 32'd7);
        clear_reqs();

        // Counter wrap
        step();
        force dut.op_count_q = 32'hFFFFFFFF;
        #1 release dut.op_count_q;
        check("wrap_pre", op_count, 32'hFFFFFFFF);
        set_req(0, 1'b1, 1'b0, 4'b0010, 32'd1, 32'd1);
        step();
        check("wrap_post", op_count, 32'd0);
        clear_reqs();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single-cycle RV32 `alu` between up to four requesters, such as the PC-increment path, the execute stage and the branch comparator, so the core needs only one ALU instance. Each requester uses a valid/ready handshake. The block grants one request per cycle, round-robin with an optional lock. It drives the ALU and returns a registered result tagged with the requester ID one cycle after acceptance.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2–4.
- `WIDTH`, default 32: operand/result width, must match `alu`.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req_valid  in  NUM_REQ`: request pending, one bit per requester.
- `req_lock  in  NUM_REQ`: requester asks to keep the grant after its transfer.
- `req_op1  in  NUM_REQ*WIDTH`: packed operand 1. Requester i occupies bits [i*WIDTH +: WIDTH].
- `req_op2  in  NUM_REQ*WIDTH`: packed operand 2, same packing.
- `req_alu_op  in  NUM_REQ*4`: packed ALU opcode, 4 bits per requester.
- `req_ready  out  NUM_REQ`: one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid  out  1`: a response is present this cycle.
- `rsp_id  out  2`: index of the requester that owns the response.
- `rsp_result  out  WIDTH`: ALU result.
- `rsp_zero  out  1`: ALU zero flag.
- `rsp_illegal  out  1`: the opcode was not a defined ALU opcode.
- `state_locked  out  1`: high while in state LOCK.
- `op_count  out  32`: total accepted transfers.

## Operation
- Opcodes: AND=0000, OR=0001, ADD=0010, SLT=0100, XOR=0101, SUB=0110, SRL=1000, SLL=1001, SRA=1010. Any other code is forwarded to the ALU unchanged and sets `rsp_illegal`.
- Requester protocol: once `req_valid[i]` is high, the requester holds it and its operands stable until the transfer.
- The requester must accept the response in the cycle `rsp_valid` is high. There is no response backpressure.
- State ARB:
  - Grant the first valid requester searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - On a transfer, `rr_ptr` becomes (winner+1) mod NUM_REQ.
  - If `req_lock[winner]` is 1 at that edge, go to LOCK with owner=winner.
  - No valid requester: no grant, `rr_ptr` unchanged.
- State LOCK:
  - Only the owner can be granted. `req_ready[owner]` = `req_valid[owner]`.
  - Go to ARB at any edge where `req_lock[owner]` is 0, with `rr_ptr` = owner+1.
  - The owner may transfer in the releasing cycle.
- ALU inputs are a mux of the granted requester's fields, combinational.
- On a transfer, register the ALU outputs, the ID and the illegal flag.
- `op_count` increments per transfer and wraps from 0xFFFFFFFF to 0.

## Timing
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`. It has no combinational path from `req_op*`.
- Response latency is exactly 1 cycle: a transfer at edge N gives `rsp_valid` high for the cycle after edge N.
- Back-to-back transfers sustain 1 per cycle.
- `rsp_valid` is 0 in any cycle that follows an edge with no transfer. `rsp_result`/`rsp_zero`/`rsp_id`/`rsp_illegal` hold their last values.
- Reset values:
  - state ARB, `rr_ptr` 0, `req_ready` 0.
  - `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_zero` 0, `rsp_illegal` 0.
  - `state_locked` 0, `op_count` 0.
- Reset asserted mid-operation drops any in-flight response immediately and clears the lock. `req_ready` is forced to 0 while `rst` is high.
- Simultaneous requests in ARB: exactly one grant, chosen by the rotation order from `rr_ptr`.

## Structure
- Shared include `alu_defs.vh` holds the ALU opcode constants (`ALU_AND` … `ALU_SRA`) and the state encodings. `alu`, this block and the decoder use it.
- One natural sub-module, `rr_arbiter`, is the rotating-priority one-hot picker with inputs `req` and `ptr`.
- Instantiate the existing `alu` once. FSM, lock, response register and counter stay in the top.

## Test plan
- Single request, ADD: requester 0 sends ADD 20 + 22. Expect `req_ready[0]` in the same cycle, then next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0x0000002A, `rsp_zero`=0.
- Contention, NUM_REQ=2: both requesters valid continuously; requester 0 sends SUB 50−30, requester 1 sends AND A5A5A5A5 & 5A5A5A5A.
  - Grants alternate 0,1,0,1.
  - Responses are 0x14 (id 0) and 0x00000000 with `rsp_zero`=1 (id 1).
- Lock: requester 1 holds lock for 3 transfers (SRL, SLL, SRA of 0xFFFFFFFF by 4) while requester 0 stays valid.
  - Results are 0x0FFFFFFF, 0xFFFFFFF0, 0xFFFFFFFF, with no grant to requester 0.
  - Requester 0 is granted the cycle after lock drops.
- Illegal opcode: 4'b1111 → `rsp_illegal`=1 with `rsp_valid`=1. A following XOR 12345678 ^ 87654321 → 0x95511559, `rsp_illegal`=0.
- Reset mid-lock: assert `rst` asynchronously between edges while LOCK is active with a response pending.
  - `rsp_valid`, `req_ready`, `state_locked` and `op_count` go to 0 immediately.
  - After release, the first grant goes to requester 0.
- Counter wrap: force `op_count` to 0xFFFFFFFF, do one transfer → 0.
